// File: rtl/maria_pkg.sv
// -----------------------------------------------------------------------------
// maria_pkg
// Shared types and constants for the Maria bus arbitration logic.
//   arb_state_t        : arbiter FSM state encoding
//   ARB_HALT_DELAY_MAX : largest supported halt settle delay (mclk0 ticks)
//   ARB_DELAY_W        : width of the settle-delay counter
//   arb_halts_cpu()    : true for states in which the 6502 is held halted
// -----------------------------------------------------------------------------
package maria_pkg;

   typedef enum logic [2:0] {
      ARB_CPU,
      ARB_HALT_PEND,
      ARB_HALT_WAIT,
      ARB_DMA,
      ARB_DBG,
      ARB_RELEASE
   } arb_state_t;

   localparam int unsigned ARB_HALT_DELAY_MAX = 7;
   localparam int unsigned ARB_DELAY_W        = 3;

   function automatic logic arb_halts_cpu(input arb_state_t s);
      return (s == ARB_HALT_PEND) || (s == ARB_HALT_WAIT) ||
             (s == ARB_DMA)       || (s == ARB_DBG);
   endfunction

endpackage

// File: rtl/maria_tick_counter.sv
// -----------------------------------------------------------------------------
// maria_tick_counter
// Saturating up-counter with synchronous clear and count enable.
// Clear has priority over a coincident enable.
//   i_clk_sys  : system clock
//   i_reset_b  : asynchronous active-low reset
//   i_clr      : clear count to zero
//   i_en       : increment by one (holds at all-ones)
//   o_count    : current count
// -----------------------------------------------------------------------------
module maria_tick_counter #(
   parameter int unsigned W = 13
) (
   input  logic         i_clk_sys,
   input  logic         i_reset_b,
   input  logic         i_clr,
   input  logic         i_en,
   output logic [W-1:0] o_count
);

   logic [W-1:0] r_count;

   always_ff @(posedge i_clk_sys or negedge i_reset_b) begin
      if (!i_reset_b) begin
         r_count <= '0;
      end else if (i_clr) begin
         r_count <= '0;
      end else if (i_en && (r_count != '1)) begin
         r_count <= r_count + 1'b1;
      end
   end

   assign o_count = r_count;

endmodule

// File: rtl/maria_bus_arbiter.sv
// -----------------------------------------------------------------------------
// maria_bus_arbiter
// Shares the system bus between the 6502, Maria DMA and the debug port.
// Sequences halt -> CPU cycle boundary -> settle delay -> grant, and counts
// mclk0 ticks spent with the CPU halted since the last line restart.
//   clk_sys      : system clock (all strobes are one clk_sys wide)
//   reset_b      : asynchronous active-low reset
//   mclk0/mclk1  : Maria phase strobes (mclk0 is the FSM step enable)
//   pclk1        : CPU cycle-boundary strobe
//   lrc          : line restart, clears halted_ticks
//   dma_req/done : DMA request level / burst-complete (sampled on mclk1)
//   dbg_req      : debug port request level
//   halt_b       : CPU halt, active-low
//   dma_grant    : DMA owns the bus
//   dbg_grant    : debug port owns the bus
//   drive_AB     : Maria drives the address bus
//   busy         : arbiter not idle in CPU state
//   halted_ticks : mclk0 ticks with halt_b low since last lrc (saturating)
// -----------------------------------------------------------------------------
module maria_bus_arbiter
   import maria_pkg::*;
#(
   parameter int unsigned HALT_DELAY = 2,
   parameter int unsigned CNT_W      = 13
) (
   input  logic             clk_sys,
   input  logic             reset_b,
   input  logic             mclk0,
   input  logic             mclk1,
   input  logic             pclk1,
   input  logic             lrc,
   input  logic             dma_req,
   input  logic             dma_done,
   input  logic             dbg_req,
   output logic             halt_b,
   output logic             dma_grant,
   output logic             dbg_grant,
   output logic             drive_AB,
   output logic             busy,
   output logic [CNT_W-1:0] halted_ticks
);

   localparam logic [ARB_DELAY_W-1:0] LP_DELAY = ARB_DELAY_W'(HALT_DELAY);

   arb_state_t             r_state;
   arb_state_t             w_next;
   logic [ARB_DELAY_W-1:0] r_delay;
   logic [ARB_DELAY_W-1:0] w_delay_next;
   logic                   r_done_seen;
   logic                   w_done_next;

   logic r_halt_b;
   logic r_dma_grant;
   logic r_dbg_grant;
   logic r_drive_AB;
   logic r_busy;

   logic w_any_req;
   logic w_tick_en;

   assign w_any_req = dma_req | dbg_req;

   // Next-state logic. The only transition not gated by mclk0 is the
   // HALT_PEND exit on pclk1, which also wins over a coincident mclk0.
   always_comb begin
      w_next       = r_state;
      w_delay_next = r_delay;
      w_done_next  = r_done_seen;
      unique case (r_state)
         ARB_CPU: begin
            if (mclk0 && w_any_req) w_next = ARB_HALT_PEND;
         end
         ARB_HALT_PEND: begin
            if (pclk1) begin
               w_next       = ARB_HALT_WAIT;
               w_delay_next = LP_DELAY;
            end else if (mclk0 && !w_any_req) begin
               w_next = ARB_RELEASE;
            end
         end
         ARB_HALT_WAIT: begin
            if (mclk0) begin
               if (r_delay <= ARB_DELAY_W'(1)) begin
                  w_delay_next = '0;
                  if (dma_req)      w_next = ARB_DMA;
                  else if (dbg_req) w_next = ARB_DBG;
                  else              w_next = ARB_RELEASE;
               end else begin
                  w_delay_next = r_delay - 1'b1;
               end
            end
         end
         ARB_DMA: begin
            if (mclk1 && dma_done) w_done_next = 1'b1;
            // Exit is evaluated after the sample so that clearing the flag
            // on the leaving mclk0 takes precedence.
            if (mclk0 && r_done_seen) begin
               w_done_next = 1'b0;
               w_next      = dbg_req ? ARB_DBG : ARB_RELEASE;
            end
         end
         ARB_DBG: begin
            if (mclk0) begin
               if (dma_req)       w_next = ARB_DMA;
               else if (!dbg_req) w_next = ARB_RELEASE;
            end
         end
         ARB_RELEASE: begin
            if (mclk0) w_next = ARB_CPU;
         end
         default: begin
            w_next = ARB_CPU;
         end
      endcase
   end

   // State and registered outputs. Outputs are decoded from the next state
   // so that a DBG->DMA handover swaps the grants on the same edge and
   // drive_AB stays high throughout.
   always_ff @(posedge clk_sys or negedge reset_b) begin
      if (!reset_b) begin
         r_state     <= ARB_CPU;
         r_delay     <= '0;
         r_done_seen <= 1'b0;
         r_halt_b    <= 1'b1;
         r_dma_grant <= 1'b0;
         r_dbg_grant <= 1'b0;
         r_drive_AB  <= 1'b0;
         r_busy      <= 1'b0;
      end else begin
         r_state     <= w_next;
         r_delay     <= w_delay_next;
         r_done_seen <= w_done_next;
         r_halt_b    <= !arb_halts_cpu(w_next);
         r_dma_grant <= (w_next == ARB_DMA);
         r_dbg_grant <= (w_next == ARB_DBG);
         r_drive_AB  <= (w_next == ARB_DMA) || (w_next == ARB_DBG);
         r_busy      <= (w_next != ARB_CPU);
      end
   end

   assign w_tick_en = mclk0 & ~r_halt_b;

   maria_tick_counter #(
      .W (CNT_W)
   ) u_halted_ticks (
      .i_clk_sys (clk_sys),
      .i_reset_b (reset_b),
      .i_clr     (lrc),
      .i_en      (w_tick_en),
      .o_count   (halted_ticks)
   );

   assign halt_b    = r_halt_b;
   assign dma_grant = r_dma_grant;
   assign dbg_grant = r_dbg_grant;
   assign drive_AB  = r_drive_AB;
   assign busy      = r_busy;

endmodule

// File: tb/tb_maria_bus_arbiter.sv
// -----------------------------------------------------------------------------
// tb_maria_bus_arbiter
// Directed bench for maria_bus_arbiter. Strobes are driven one clk_sys wide
// on the falling edge; outputs are sampled 1 time unit after the rising edge.
// One "mstep" is a four-cycle Maria frame: mclk0, idle, mclk1, idle.
// -----------------------------------------------------------------------------
module tb_maria_bus_arbiter;

   localparam int unsigned CNT_W = 13;

   logic             clk_sys = 1'b0;
   logic             reset_b;
   logic             mclk0, mclk1, pclk1, lrc;
   logic             dma_req, dma_done, dbg_req;
   logic             halt_b, dma_grant, dbg_grant, drive_AB, busy;
   logic [CNT_W-1:0] halted_ticks;

   int unsigned n_tests = 0;
   int unsigned n_fail  = 0;

   always #5 clk_sys = ~clk_sys;

   maria_bus_arbiter #(
      .HALT_DELAY (2),
      .CNT_W      (CNT_W)
   ) dut (
      .clk_sys      (clk_sys),
      .reset_b      (reset_b),
      .mclk0        (mclk0),
      .mclk1        (mclk1),
      .pclk1        (pclk1),
      .lrc          (lrc),
      .dma_req      (dma_req),
      .dma_done     (dma_done),
      .dbg_req      (dbg_req),
      .halt_b       (halt_b),
      .dma_grant    (dma_grant),
      .dbg_grant    (dbg_grant),
      .drive_AB     (drive_AB),
      .busy         (busy),
      .halted_ticks (halted_ticks)
   );

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic expect_out(input string tag, input logic h, input logic dg,
                             input logic bg, input logic bz, input int unsigned t);
      chk({tag, ".halt_b"},       32'(halt_b),       32'(h));
      chk({tag, ".dma_grant"},    32'(dma_grant),    32'(dg));
      chk({tag, ".dbg_grant"},    32'(dbg_grant),    32'(bg));
      chk({tag, ".drive_AB"},     32'(drive_AB),     32'(dg | bg));
      chk({tag, ".busy"},         32'(busy),         32'(bz));
      chk({tag, ".halted_ticks"}, 32'(halted_ticks), t);
   endtask

   task automatic cyc(input logic m0, input logic m1, input logic p1, input logic l);
      @(negedge clk_sys);
      mclk0 = m0; mclk1 = m1; pclk1 = p1; lrc = l;
      @(posedge clk_sys);
      #1;
      mclk0 = 1'b0; mclk1 = 1'b0; pclk1 = 1'b0; lrc = 1'b0;
   endtask

   task automatic mstep();
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   task automatic mstep_lrc();
      cyc(1'b1, 1'b0, 1'b0, 1'b1);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
   endtask

   initial begin
      reset_b = 1'b0;
      mclk0 = 1'b0; mclk1 = 1'b0; pclk1 = 1'b0; lrc = 1'b0;
      dma_req = 1'b1; dma_done = 1'b0; dbg_req = 1'b0;

      // Reset held with a pending request, even across an mclk0
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      expect_out("rst", 1, 0, 0, 0, 0);
      cyc(1'b1, 1'b0, 1'b0, 1'b0);
      expect_out("rst_mclk0", 1, 0, 0, 0, 0);

      // Release reset: halt_b must wait for the first mclk0
      @(negedge clk_sys);
      reset_b = 1'b1;
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      expect_out("post_rst_idle", 1, 0, 0, 0, 0);
      mstep();
      expect_out("first_mclk0", 0, 0, 0, 1, 0);

      // DMA: pclk1 three mclk0 after request, grant two mclk0 after pclk1
      mstep(); expect_out("pend1", 0, 0, 0, 1, 1);
      mstep(); expect_out("pend2", 0, 0, 0, 1, 2);
      mstep(); expect_out("pend3", 0, 0, 0, 1, 3);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      expect_out("pclk1", 0, 0, 0, 1, 3);
      mstep(); expect_out("wait1", 0, 0, 0, 1, 4);
      mstep(); expect_out("grant_dma", 0, 1, 0, 1, 5);
      dma_req = 1'b0; dma_done = 1'b1;
      mstep(); dma_done = 1'b0;
      expect_out("dma_done_seen", 0, 1, 0, 1, 6);
      mstep(); expect_out("release", 1, 0, 0, 1, 7);
      mstep(); expect_out("cpu", 1, 0, 0, 0, 7);
      dma_done = 1'b1;
      mstep(); dma_done = 1'b0;
      expect_out("done_ignored", 1, 0, 0, 0, 7);

      // DBG, DMA preemption, return to DBG without re-halt
      dbg_req = 1'b1;
      mstep(); expect_out("dbg_pend", 0, 0, 0, 1, 7);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      mstep(); expect_out("dbg_wait", 0, 0, 0, 1, 8);
      mstep(); expect_out("dbg_grant", 0, 0, 1, 1, 9);
      mstep(); expect_out("dbg_hold", 0, 0, 1, 1, 10);
      dma_req = 1'b1;
      mstep(); expect_out("preempt", 0, 1, 0, 1, 11);
      dma_req = 1'b0; dma_done = 1'b1;
      mstep(); dma_done = 1'b0;
      expect_out("preempt_done", 0, 1, 0, 1, 12);
      mstep(); expect_out("back_dbg", 0, 0, 1, 1, 13);
      dbg_req = 1'b0;
      mstep(); expect_out("dbg_rel", 1, 0, 0, 1, 14);
      mstep(); expect_out("cpu2", 1, 0, 0, 0, 14);

      // Both requests together: DMA first, then DBG, halt held throughout
      dma_req = 1'b1; dbg_req = 1'b1;
      mstep(); expect_out("both_pend", 0, 0, 0, 1, 14);
      cyc(1'b0, 1'b0, 1'b1, 1'b0);
      mstep(); expect_out("both_wait", 0, 0, 0, 1, 15);
      mstep(); expect_out("both_dma", 0, 1, 0, 1, 16);
      dma_req = 1'b0; dma_done = 1'b1;
      mstep(); dma_done = 1'b0;
      expect_out("both_done", 0, 1, 0, 1, 17);
      mstep(); expect_out("both_dbg", 0, 0, 1, 1, 18);
      dbg_req = 1'b0;
      mstep(); expect_out("both_rel", 1, 0, 0, 1, 19);
      mstep(); expect_out("cpu3", 1, 0, 0, 0, 19);

      // Requests drop in HALT_PEND; request in RELEASE goes via CPU
      dbg_req = 1'b1;
      mstep(); expect_out("drop_pend", 0, 0, 0, 1, 19);
      dbg_req = 1'b0;
      mstep(); expect_out("drop_rel", 1, 0, 0, 1, 20);
      dma_req = 1'b1;
      mstep(); expect_out("rel_to_cpu", 1, 0, 0, 0, 20);
      mstep(); expect_out("cpu_to_pend", 0, 0, 0, 1, 20);

      // pclk1 coincident with mclk0: load now, decrement from next mclk0
      cyc(1'b1, 1'b0, 1'b1, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      cyc(1'b0, 1'b1, 1'b0, 1'b0);
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      expect_out("pclk_mclk", 0, 0, 0, 1, 21);
      mstep(); expect_out("pm_wait", 0, 0, 0, 1, 22);
      mstep(); expect_out("pm_dma", 0, 1, 0, 1, 23);

      // lrc wins over a coincident increment
      mstep_lrc(); expect_out("lrc_clr", 0, 1, 0, 1, 0);

      // Saturation
      for (int i = 0; i < 9000; i++) mstep();
      expect_out("sat", 0, 1, 0, 1, 8191);
      mstep(); expect_out("sat_hold", 0, 1, 0, 1, 8191);
      mstep_lrc(); expect_out("sat_lrc", 0, 1, 0, 1, 0);
      mstep(); expect_out("post_lrc", 0, 1, 0, 1, 1);

      // Asynchronous reset mid-burst, between clock edges
      #2;
      reset_b = 1'b0;
      #1;
      expect_out("async_rst", 1, 0, 0, 0, 0);
      dma_req = 1'b0;
      @(negedge clk_sys);
      reset_b = 1'b1;
      cyc(1'b0, 1'b0, 1'b0, 1'b0);
      mstep(); expect_out("after_rst", 1, 0, 0, 0, 0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
